// File: rtl/stack_queue_engine.sv
// Operand store for the calculator datapath: a single buffer used as a LIFO or a FIFO, with an exec sequence driving a binary ALU.
// Optional: define SQE_STICKY_ERR_EN to hold err until rst or a successful push.
module stack_queue_engine #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              push,
    input  logic              pop,
    input  logic              exec,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] alu_y,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] front,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              busy,
    output logic              err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        OPER,
        WB
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              mode_q;

    // Stack mode keeps head fixed and uses tail as the stack pointer, so
    // tail - head == count (mod DEPTH) in both modes and switching when empty is safe.
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W-1:0]  sec_ptr;
    logic [PTR_W-1:0]  nxt_ptr;

    assign top_ptr = tail - PTR_W'(1);
    assign sec_ptr = tail - PTR_W'(2);
    assign nxt_ptr = head + PTR_W'(1);

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign front = empty ? '0 : (mode_q ? mem[head] : mem[top_ptr]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            head   <= '0;
            tail   <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
`ifndef SQE_STICKY_ERR_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (count == '0) begin
                        mode_q <= mode;
                    end
                    if (exec) begin
                        if (count < CNT_W'(2)) begin
                            err <= 1'b1;
                        end else begin
                            if (mode_q) begin
                                alu_a <= mem[head];
                                alu_b <= mem[nxt_ptr];
                                head  <= head + PTR_W'(2);
                            end else begin
                                alu_a <= mem[sec_ptr];
                                alu_b <= mem[top_ptr];
                                tail  <= sec_ptr;
                            end
                            count <= count - CNT_W'(2);
                            busy  <= 1'b1;
                            state <= OPER;
                        end
                    end else if (pop) begin
                        if (empty) begin
                            err <= 1'b1;
                        end else begin
                            if (mode_q) begin
                                head <= nxt_ptr;
                            end else begin
                                tail <= top_ptr;
                            end
                            count <= count - CNT_W'(1);
                        end
                    end else if (push) begin
                        if (full) begin
                            err <= 1'b1;
                        end else begin
                            mem[tail] <= din;
                            tail      <= tail + PTR_W'(1);
                            count     <= count + CNT_W'(1);
`ifdef SQE_STICKY_ERR_EN
                            err       <= 1'b0;
`endif
                        end
                    end
                end
                OPER: begin
                    state <= WB;
                end
                WB: begin
                    // Net occupancy of an exec is -1, so this write can never overflow.
                    mem[tail] <= alu_y;
                    tail      <= tail + PTR_W'(1);
                    count     <= count + CNT_W'(1);
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_queue_engine.sv
// Bench for stack_queue_engine (DATA_W=8, DEPTH=4): directed scenarios plus randomized traffic against a queue-based model.
module tb_stack_queue_engine;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              mode_s = 1'b0;
    logic              push_s = 1'b0;
    logic              pop_s = 1'b0;
    logic              exec_s = 1'b0;
    logic [DATA_W-1:0] din_s = '0;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] front;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              busy;
    logic              err;
    logic              op_sub = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // ALU stub
    assign alu_y = op_sub ? alu_a - alu_b : alu_a + alu_b;

    stack_queue_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mode(mode_s), .push(push_s), .pop(pop_s),
        .exec(exec_s), .din(din_s), .alu_y(alu_y), .alu_a(alu_a), .alu_b(alu_b),
        .front(front), .count(count), .empty(empty), .full(full),
        .busy(busy), .err(err)
    );

    // Reference model: contents as an ordered list, oldest first.
    logic [DATA_W-1:0] q[$];
    bit                m_mode;
    bit                m_err;
    int                m_busy;
    logic [DATA_W-1:0] m_a;
    logic [DATA_W-1:0] m_b;

    function automatic void model_reset();
        q.delete();
        m_mode = 0;
        m_err  = 0;
        m_busy = 0;
        m_a    = '0;
        m_b    = '0;
    endfunction

    function automatic void model_cycle(bit p, bit po, bit e, logic [DATA_W-1:0] d, bit md, bit sub);
        bit rej = 0;
        bit ok_push = 0;
        bit was_empty;
        if (m_busy == 2) begin
            m_busy = 1;
        end else if (m_busy == 1) begin
            q.push_back(sub ? m_a - m_b : m_a + m_b);
            m_busy = 0;
        end else begin
            was_empty = (q.size() == 0);
            if (e) begin
                if (q.size() < 2) rej = 1;
                else begin
                    if (m_mode) begin
                        m_a = q[0];
                        m_b = q[1];
                        void'(q.pop_front());
                        void'(q.pop_front());
                    end else begin
                        m_a = q[q.size()-2];
                        m_b = q[q.size()-1];
                        void'(q.pop_back());
                        void'(q.pop_back());
                    end
                    m_busy = 2;
                end
            end else if (po) begin
                if (q.size() == 0) rej = 1;
                else if (m_mode) void'(q.pop_front());
                else void'(q.pop_back());
            end else if (p) begin
                if (q.size() == DEPTH) rej = 1;
                else begin
                    q.push_back(d);
                    ok_push = 1;
                end
            end
            if (was_empty) m_mode = md;
        end
`ifdef SQE_STICKY_ERR_EN
        if (rej) m_err = 1;
        else if (ok_push) m_err = 0;
`else
        m_err = rej;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] m_front();
        if (q.size() == 0) return '0;
        return m_mode ? q[0] : q[q.size()-1];
    endfunction

    task automatic tick(input bit p, input bit po, input bit e, input logic [DATA_W-1:0] d, input bit r);
        push_s = p;
        pop_s  = po;
        exec_s = e;
        din_s  = d;
        rst    = r;
        @(posedge clk);
        if (r) model_reset();
        else model_cycle(p, po, e, d, mode_s, op_sub);
        #1;
        push_s = 0;
        pop_s  = 0;
        exec_s = 0;
        rst    = 0;
    endtask

    task automatic test_reset();
        mode_s = 0;
        tick(0, 0, 0, 0, 1);
        n_total++; if (count !== 0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
        n_total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); else n_pass++;
        n_total++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL reset_busy_err busy=%b err=%b exp 0/0", busy, err); else n_pass++;
        n_total++; if (alu_a !== 0 || alu_b !== 0 || front !== 0) $display("FAIL reset_data a=%0d b=%0d front=%0d exp 0", alu_a, alu_b, front); else n_pass++;
    endtask

    task automatic test_stack_exec();
        mode_s = 0; op_sub = 1;
        tick(0, 0, 0, 0, 1);
        tick(1, 0, 0, 8'd5, 0);
        tick(1, 0, 0, 8'd3, 0);
        tick(0, 0, 1, 0, 0);
        n_total++; if (alu_a !== 8'd5 || alu_b !== 8'd3) $display("FAIL stack_exec_operands a=%0d b=%0d exp 5/3", alu_a, alu_b); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL stack_exec_busy1 got=%b exp=1", busy); else n_pass++;
        tick(0, 0, 0, 0, 0);
        n_total++; if (busy !== 1'b1) $display("FAIL stack_exec_busy2 got=%b exp=1", busy); else n_pass++;
        tick(0, 0, 0, 0, 0);
        n_total++; if (busy !== 1'b0 || front !== 8'd2 || count !== 1) $display("FAIL stack_exec_result busy=%b front=%0d count=%0d exp 0/2/1", busy, front, count); else n_pass++;
    endtask

    task automatic test_queue_exec();
        mode_s = 1; op_sub = 0;
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 8'd9, 0);
        tick(1, 0, 0, 8'd4, 0);
        tick(1, 0, 0, 8'd1, 0);
        tick(0, 0, 1, 0, 0);
        n_total++; if (alu_a !== 8'd9 || alu_b !== 8'd4) $display("FAIL queue_exec_operands a=%0d b=%0d exp 9/4", alu_a, alu_b); else n_pass++;
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        n_total++; if (front !== 8'd1 || count !== 2) $display("FAIL queue_exec_result front=%0d count=%0d exp 1/2", front, count); else n_pass++;
        tick(0, 1, 0, 0, 0);
        n_total++; if (front !== 8'd13) $display("FAIL queue_exec_tail front=%0d exp=13", front); else n_pass++;
    endtask

    task automatic test_queue_wrap();
        logic [DATA_W-1:0] exp_vals[3] = '{8'd4, 8'd7, 8'd8};
        mode_s = 1;
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) tick(1, 0, 0, DATA_W'(i), 0);
        n_total++; if (full !== 1'b1) $display("FAIL wrap_full got=%b exp=1", full); else n_pass++;
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
        tick(1, 0, 0, 8'd7, 0);
        tick(1, 0, 0, 8'd8, 0);
        n_total++; if (count !== 3 || front !== 8'd4) $display("FAIL wrap_state count=%0d front=%0d exp 3/4", count, front); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (front !== exp_vals[i]) $display("FAIL wrap_pop%0d front=%0d exp=%0d", i, front, exp_vals[i]); else n_pass++;
            tick(0, 1, 0, 0, 0);
        end
        n_total++; if (empty !== 1'b1) $display("FAIL wrap_empty got=%b exp=1", empty); else n_pass++;
    endtask

    task automatic test_errors();
        mode_s = 0;
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, DATA_W'(i + 20), 0);
        tick(1, 0, 0, 8'd99, 0);
        n_total++; if (err !== 1'b1 || count !== 4) $display("FAIL overflow err=%b count=%0d exp 1/4", err, count); else n_pass++;
        n_total++; if (front !== 8'd23) $display("FAIL overflow_front got=%0d exp=23", front); else n_pass++;
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 0);
        n_total++; if (err !== 1'b0) $display("FAIL err_cleared got=%b exp=0", err); else n_pass++;
        tick(0, 1, 0, 0, 0);
        n_total++; if (err !== 1'b1 || count !== 0) $display("FAIL underflow err=%b count=%0d exp 1/0", err, count); else n_pass++;
        tick(1, 0, 0, 8'd6, 0);
        tick(0, 0, 1, 0, 0);
        n_total++; if (err !== 1'b1 || busy !== 1'b0 || count !== 1) $display("FAIL exec_short err=%b busy=%b count=%0d exp 1/0/1", err, busy, count); else n_pass++;
    endtask

    task automatic test_priority();
        mode_s = 0;
        tick(0, 0, 0, 0, 1);
        tick(1, 0, 0, 8'd1, 0);
        tick(1, 0, 0, 8'd2, 0);
        tick(1, 1, 0, 8'd50, 0);
        n_total++; if (count !== 1 || front !== 8'd1 || err !== 1'b0) $display("FAIL push_pop_prio count=%0d front=%0d err=%b exp 1/1/0", count, front, err); else n_pass++;
        tick(1, 0, 0, 8'd2, 0);
        mode_s = 1;
        tick(0, 0, 0, 0, 0);
        n_total++; if (front !== 8'd2) $display("FAIL mode_ignored front=%0d exp=2", front); else n_pass++;
        tick(0, 1, 0, 0, 0);
        n_total++; if (front !== 8'd1) $display("FAIL mode_ignored_pop front=%0d exp=1", front); else n_pass++;
    endtask

    task automatic test_rst_abort();
        mode_s = 0; op_sub = 0;
        tick(0, 0, 0, 0, 1);
        tick(1, 0, 0, 8'd10, 0);
        tick(1, 0, 0, 8'd20, 0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 1);
        n_total++; if (count !== 0 || busy !== 1'b0 || empty !== 1'b1) $display("FAIL abort_state count=%0d busy=%b empty=%b exp 0/0/1", count, busy, empty); else n_pass++;
        n_total++; if (alu_a !== 0 || alu_b !== 0) $display("FAIL abort_alu a=%0d b=%0d exp 0/0", alu_a, alu_b); else n_pass++;
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        n_total++; if (count !== 0) $display("FAIL abort_no_wb count=%0d exp=0", count); else n_pass++;
    endtask

    task automatic test_err_hold();
        mode_s = 0;
        tick(0, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0);
        n_total++; if (err !== 1'b1) $display("FAIL err_set got=%b exp=1", err); else n_pass++;
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        n_total++; if (err !== m_err) $display("FAIL err_hold got=%b exp=%b", err, m_err); else n_pass++;
        tick(1, 0, 0, 8'd3, 0);
        n_total++; if (err !== 1'b0) $display("FAIL err_push_clear got=%b exp=0", err); else n_pass++;
    endtask

    task automatic test_random();
        bit p, po, e;
        mode_s = 0;
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            p  = ($urandom_range(0, 99) < 45);
            po = ($urandom_range(0, 99) < 30);
            e  = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 9) == 0) mode_s = ~mode_s;
            op_sub = $urandom_range(0, 1);
            tick(p, po, e, DATA_W'($urandom), ($urandom_range(0, 199) == 0));
            n_total++;
            if (count !== CNT_W'(q.size()) || front !== m_front() || busy !== (m_busy != 0) ||
                err !== m_err || empty !== (q.size() == 0) || full !== (q.size() == DEPTH))
                $display("FAIL rand_status[%0d] count=%0d/%0d front=%0d/%0d busy=%b/%b err=%b/%b empty=%b full=%b",
                         i, count, q.size(), front, m_front(), busy, (m_busy != 0), err, m_err, empty, full);
            else n_pass++;
            n_total++;
            if (alu_a !== m_a || alu_b !== m_b)
                $display("FAIL rand_alu[%0d] a=%0d/%0d b=%0d/%0d", i, alu_a, m_a, alu_b, m_b);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_stack_exec();
        test_queue_exec();
        test_queue_wrap();
        test_errors();
        test_priority();
        test_rst_abort();
        test_err_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
